// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and run control for a five-stage pipeline (IF, ID, EX, MEM,
// WB). Drives enable/stall/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB
// segment registers, selects EX-stage operand forwarding, detects load-use
// hazards and taken branches, freezes the pipe while data memory is busy and
// implements a halt / single-step debug FSM.
//
// Parameters:
//   MAX_WAIT   consecutive MEM_WAIT cycles tolerated before a timeout (1..255)
//   START_RUN  state after reset: 1 = RUN, 0 = HALT
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   rf_ra0_id/rf_ra1_id            ID-stage source registers
//   rf_re0_id/rf_re1_id            ID-stage source read valid
//   rf_ra0_ex/rf_ra1_ex            EX-stage source registers
//   rf_wa_{ex,mem,wb}              destination register per stage
//   rf_we_{ex,mem,wb}              destination write enable per stage
//   is_load_ex                     EX instruction is a load
//   br_taken_ex                    EX branch/jump resolved taken
//   dmem_req_mem, dmem_ready       MEM-stage data access handshake
//   halt_req (level), step_req (pulse)   debug run control
//   stall_pc                       hold the PC
//   en_*                           segment register enables
//   stall_if_id, stall_id_ex       segment stalls
//   flush_if_id, flush_id_ex       segment flushes (insert NOP)
//   fwd0_sel, fwd1_sel             00 regfile, 01 MEM result, 10 WB result
//   halted                         FSM in HALT
//   mem_timeout                    sticky: MAX_WAIT exceeded, cleared by rst
//
// Optional feature (macro PIPE_PERF_CNT_EN): adds free-running 32-bit
// counters stall_cycles, flush_cycles and memwait_cycles.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_WAIT  = 16,
    parameter int unsigned START_RUN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rf_ra0_id,
    input  logic [4:0]  rf_ra1_id,
    input  logic        rf_re0_id,
    input  logic        rf_re1_id,
    input  logic [4:0]  rf_ra0_ex,
    input  logic [4:0]  rf_ra1_ex,
    input  logic [4:0]  rf_wa_ex,
    input  logic [4:0]  rf_wa_mem,
    input  logic [4:0]  rf_wa_wb,
    input  logic        rf_we_ex,
    input  logic        rf_we_mem,
    input  logic        rf_we_wb,
    input  logic        is_load_ex,
    input  logic        br_taken_ex,
    input  logic        dmem_req_mem,
    input  logic        dmem_ready,
    input  logic        halt_req,
    input  logic        step_req,
    output logic        stall_pc,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        stall_if_id,
    output logic        stall_id_ex,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [1:0]  fwd0_sel,
    output logic [1:0]  fwd1_sel,
    output logic        halted,
    output logic        mem_timeout
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles,
    output logic [31:0] memwait_cycles
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_HALT     = 2'd2,
        S_STEP     = 2'd3
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       timeout_set;
    logic       advance;      // every segment register loads this cycle
    logic       mem_busy;
    logic       load_use;
    logic       br_flush;     // taken branch acted on this cycle
    logic       lu_stall;     // load-use bubble inserted this cycle

    assign mem_busy = dmem_req_mem && !dmem_ready;

    assign load_use = is_load_ex && rf_we_ex && (rf_wa_ex != 5'd0) &&
                      ((rf_re0_id && (rf_ra0_id == rf_wa_ex)) ||
                       (rf_re1_id && (rf_ra1_id == rf_wa_ex)));

    // Hazard responses only apply when the pipe actually moves; a frozen pipe
    // keeps the offending instructions in place and re-evaluates on resume.
    assign br_flush = advance && br_taken_ex;
    assign lu_stall = advance && !br_taken_ex && load_use;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_set  = 1'b0;
        advance      = 1'b0;
        case (state)
            S_RUN, S_STEP: begin
                if (mem_busy) begin
                    state_nxt    = S_MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else begin
                    advance = 1'b1;
                    // A step always lands back in HALT; RUN only on request.
                    if (state == S_STEP || halt_req) begin
                        state_nxt = S_HALT;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (dmem_ready) begin
                    advance   = 1'b1;
                    state_nxt = halt_req ? S_HALT : S_RUN;
                end else if (wait_cnt == MAX_WAIT_C) begin
                    timeout_set = 1'b1;
                    state_nxt   = S_HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            S_HALT: begin
                if (step_req) begin
                    state_nxt = S_STEP;
                end else if (!halt_req && !mem_timeout) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_HALT;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the pre-edge values of each other, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= (START_RUN != 0) ? S_RUN : S_HALT;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout_set) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Segment control outputs
    // ------------------------------------------------------------------
    always_comb begin
        en_if_id    = advance;
        en_id_ex    = advance;
        en_ex_mem   = advance;
        en_mem_wb   = advance;
        stall_pc    = !advance;
        stall_if_id = 1'b0;
        // ID/EX is never held while IF/ID moves: a load-use bubble flushes it,
        // and a full freeze is expressed through the enables.
        stall_id_ex = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;

        if (br_flush) begin
            // Redirect wins over load-use: PC and IF/ID must move so the
            // branch target is fetched.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (lu_stall) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end

        if (rst) begin
            en_if_id    = 1'b1;
            en_id_ex    = 1'b1;
            en_ex_mem   = 1'b1;
            en_mem_wb   = 1'b1;
            stall_pc    = 1'b0;
            stall_if_id = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding: youngest producer (MEM) wins; r0 is hard-wired zero.
    // ------------------------------------------------------------------
    always_comb begin
        fwd0_sel = 2'b00;
        fwd1_sel = 2'b00;
        if (!rst) begin
            if (rf_we_mem && rf_wa_mem != 5'd0 && rf_wa_mem == rf_ra0_ex) begin
                fwd0_sel = 2'b01;
            end else if (rf_we_wb && rf_wa_wb != 5'd0 && rf_wa_wb == rf_ra0_ex) begin
                fwd0_sel = 2'b10;
            end
            if (rf_we_mem && rf_wa_mem != 5'd0 && rf_wa_mem == rf_ra1_ex) begin
                fwd1_sel = 2'b01;
            end else if (rf_we_wb && rf_wa_wb != 5'd0 && rf_wa_wb == rf_ra1_ex) begin
                fwd1_sel = 2'b10;
            end
        end
    end

    assign halted = (state == S_HALT);

`ifdef PIPE_PERF_CNT_EN
    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles   <= 32'd0;
            flush_cycles   <= 32'd0;
            memwait_cycles <= 32'd0;
        end else begin
            if (lu_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (br_flush) begin
                flush_cycles <= flush_cycles + 32'd1;
            end
            if (state == S_MEM_WAIT) begin
                memwait_cycles <= memwait_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for pipeline_hazard_ctrl (MAX_WAIT = 4, START_RUN = 1).
// A behavioural model tracks run-control status (halted / waiting on memory /
// single-stepping / timed out) and derives every output from those flags and
// the current inputs; a compare process checks the DUT each mid-cycle.
// Directed sequences with literal expectations pin the model, followed by a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rf_ra0_id, rf_ra1_id, rf_ra0_ex, rf_ra1_ex;
    logic [4:0] rf_wa_ex, rf_wa_mem, rf_wa_wb;
    logic       rf_re0_id, rf_re1_id, rf_we_ex, rf_we_mem, rf_we_wb;
    logic       is_load_ex, br_taken_ex, dmem_req_mem, dmem_ready;
    logic       halt_req, step_req;

    logic       stall_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic       stall_if_id, stall_id_ex, flush_if_id, flush_id_ex;
    logic [1:0] fwd0_sel, fwd1_sel;
    logic       halted, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_cycles, memwait_cycles;
`endif

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .START_RUN(1)) dut (
        .clk(clk), .rst(rst),
        .rf_ra0_id(rf_ra0_id), .rf_ra1_id(rf_ra1_id),
        .rf_re0_id(rf_re0_id), .rf_re1_id(rf_re1_id),
        .rf_ra0_ex(rf_ra0_ex), .rf_ra1_ex(rf_ra1_ex),
        .rf_wa_ex(rf_wa_ex), .rf_wa_mem(rf_wa_mem), .rf_wa_wb(rf_wa_wb),
        .rf_we_ex(rf_we_ex), .rf_we_mem(rf_we_mem), .rf_we_wb(rf_we_wb),
        .is_load_ex(is_load_ex), .br_taken_ex(br_taken_ex),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .step_req(step_req),
        .stall_pc(stall_pc),
        .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
        .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd0_sel(fwd0_sel), .fwd1_sel(fwd1_sel),
        .halted(halted), .mem_timeout(mem_timeout)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles),
        .memwait_cycles(memwait_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: run-control status flags
    // ------------------------------------------------------------------
    bit m_valid = 1'b0;
    bit m_halted, m_waiting, m_stepping, m_timeout;
    int m_wait_cycles;

    always @(posedge clk) begin
        if (rst) begin
            m_valid       = 1'b1;
            m_halted      = 1'b0;
            m_waiting     = 1'b0;
            m_stepping    = 1'b0;
            m_timeout     = 1'b0;
            m_wait_cycles = 0;
        end else if (m_valid) begin
            if (m_halted) begin
                if (step_req) begin
                    m_halted   = 1'b0;
                    m_stepping = 1'b1;
                end else if (!halt_req && !m_timeout) begin
                    m_halted = 1'b0;
                end
            end else if (m_waiting) begin
                if (dmem_ready) begin
                    m_waiting = 1'b0;
                    m_halted  = halt_req;
                end else if (m_wait_cycles >= MAX_WAIT) begin
                    m_waiting = 1'b0;
                    m_timeout = 1'b1;
                    m_halted  = 1'b1;
                end else begin
                    m_wait_cycles++;
                end
            end else if (dmem_req_mem && !dmem_ready) begin
                m_waiting     = 1'b1;
                m_stepping    = 1'b0;
                m_wait_cycles = 1;
            end else if (m_stepping || halt_req) begin
                m_stepping = 1'b0;
                m_halted   = 1'b1;
            end
        end
    end

    function automatic logic [1:0] fwd_src(input logic [4:0] ra);
        if (ra == 5'd0) return 2'b00;
        if (rf_we_mem && rf_wa_mem == ra) return 2'b01;
        if (rf_we_wb && rf_wa_wb == ra) return 2'b10;
        return 2'b00;
    endfunction

    always @(negedge clk) begin
        bit moves, lu, e_en, e_spc, e_sif, e_fif, e_fid;
        logic [1:0] e_f0, e_f1;
        if (m_valid) begin
            if (m_halted) moves = 1'b0;
            else if (m_waiting) moves = dmem_ready;
            else moves = !(dmem_req_mem && !dmem_ready);
            lu = is_load_ex && rf_we_ex && rf_wa_ex != 0 &&
                 ((rf_re0_id && rf_ra0_id == rf_wa_ex) || (rf_re1_id && rf_ra1_id == rf_wa_ex));
            e_en = moves; e_spc = !moves; e_sif = 0; e_fif = 0; e_fid = 0;
            if (moves && br_taken_ex) begin
                e_fif = 1; e_fid = 1;
            end else if (moves && lu) begin
                e_spc = 1; e_sif = 1; e_fid = 1;
            end
            e_f0 = fwd_src(rf_ra0_ex);
            e_f1 = fwd_src(rf_ra1_ex);
            if (rst) begin
                e_en = 1; e_spc = 0; e_sif = 0; e_fif = 0; e_fid = 0; e_f0 = 0; e_f1 = 0;
            end
            check("m.en_if_id", en_if_id, e_en);
            check("m.en_id_ex", en_id_ex, e_en);
            check("m.en_ex_mem", en_ex_mem, e_en);
            check("m.en_mem_wb", en_mem_wb, e_en);
            check("m.stall_pc", stall_pc, e_spc);
            check("m.stall_if_id", stall_if_id, e_sif);
            check("m.stall_id_ex", stall_id_ex, 0);
            check("m.flush_if_id", flush_if_id, e_fif);
            check("m.flush_id_ex", flush_id_ex, e_fid);
            check("m.fwd0_sel", fwd0_sel, e_f0);
            check("m.fwd1_sel", fwd1_sel, e_f1);
            check("m.halted", halted, m_halted);
            check("m.mem_timeout", mem_timeout, m_timeout);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        rf_ra0_id = 0; rf_ra1_id = 0; rf_re0_id = 0; rf_re1_id = 0;
        rf_ra0_ex = 0; rf_ra1_ex = 0;
        rf_wa_ex = 0; rf_wa_mem = 0; rf_wa_wb = 0;
        rf_we_ex = 0; rf_we_mem = 0; rf_we_wb = 0;
        is_load_ex = 0; br_taken_ex = 0;
        dmem_req_mem = 0; dmem_ready = 0;
        halt_req = 0; step_req = 0;
    endtask

    task automatic load_use_inputs();
        is_load_ex = 1; rf_we_ex = 1; rf_wa_ex = 5; rf_ra1_id = 5; rf_re1_id = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1;
        // Hazard-provoking inputs must be masked while in reset.
        load_use_inputs();
        br_taken_ex = 1; rf_we_mem = 1; rf_wa_mem = 7; rf_ra0_ex = 7;
        repeat (2) step_clk();
        mid();
        check("rst en_if_id", en_if_id, 1);
        check("rst stall_pc", stall_pc, 0);
        check("rst flush_id_ex", flush_id_ex, 0);
        check("rst fwd0_sel", fwd0_sel, 0);
        check("rst halted", halted, 0);
        check("rst mem_timeout", mem_timeout, 0);
        step_clk();
        rst = 0;
        idle();

        // Load-use: one bubble, then the load has left EX.
        load_use_inputs();
        mid();
        check("lu stall_pc", stall_pc, 1);
        check("lu stall_if_id", stall_if_id, 1);
        check("lu flush_id_ex", flush_id_ex, 1);
        check("lu en_id_ex", en_id_ex, 1);
        step_clk();
        is_load_ex = 0; rf_we_ex = 0; rf_wa_ex = 0; rf_we_mem = 1; rf_wa_mem = 5;
        mid();
        check("lu after stall_pc", stall_pc, 0);
        check("lu after flush_id_ex", flush_id_ex, 0);
        step_clk();
        idle();
        is_load_ex = 1; rf_we_ex = 1; rf_wa_ex = 0; rf_ra1_id = 0; rf_re1_id = 1;
        mid();
        check("lu r0 stall_pc", stall_pc, 0);
        step_clk();

        // Branch beats load-use.
        idle(); load_use_inputs(); br_taken_ex = 1;
        mid();
        check("br flush_if_id", flush_if_id, 1);
        check("br flush_id_ex", flush_id_ex, 1);
        check("br stall_pc", stall_pc, 0);
        check("br stall_if_id", stall_if_id, 0);
        step_clk();

        // Forwarding.
        idle();
        rf_wa_mem = 7; rf_wa_wb = 7; rf_we_mem = 1; rf_we_wb = 1; rf_ra0_ex = 7;
        mid(); check("fwd mem", fwd0_sel, 2'b01);
        step_clk(); rf_we_mem = 0;
        mid(); check("fwd wb", fwd0_sel, 2'b10);
        step_clk(); rf_ra0_ex = 0;
        mid(); check("fwd r0", fwd0_sel, 2'b00);
        step_clk();

        // Memory wait: three not-ready cycles then ready.
        idle(); dmem_req_mem = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("mw en_mem_wb", en_mem_wb, 0);
            check("mw stall_pc", stall_pc, 1);
            step_clk();
        end
        dmem_ready = 1;
        mid();
        check("mw ready en_if_id", en_if_id, 1);
        check("mw ready stall_pc", stall_pc, 0);
        step_clk();
        idle();
        mid();
        check("mw back en_if_id", en_if_id, 1);
        check("mw back halted", halted, 0);
        step_clk();

        // Timeout: ready never comes.
        dmem_req_mem = 1; dmem_ready = 0;
        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            mid();
            check("to en_ex_mem", en_ex_mem, 0);
            check("to halted early", halted, 0);
            step_clk();
        end
        mid();
        check("to halted", halted, 1);
        check("to mem_timeout", mem_timeout, 1);
        step_clk();
        idle();
        for (int i = 0; i < 3; i++) begin
            mid();
            check("to stays halted", halted, 1);
            step_clk();
        end

        // Step from timed-out HALT straight into MEM_WAIT, then reset.
        step_req = 1; dmem_req_mem = 1; dmem_ready = 0;
        mid(); check("st halt en", en_if_id, 0);
        step_clk(); step_req = 0;
        mid();
        check("st step halted", halted, 0);
        check("st step busy en", en_if_id, 0);
        step_clk();
        mid(); check("st memwait halted", halted, 0);
        step_clk();
        rst = 1; load_use_inputs(); br_taken_ex = 1;
        mid();
        check("rmw en_id_ex", en_id_ex, 1);
        check("rmw flush_if_id", flush_if_id, 0);
        check("rmw stall_if_id", stall_if_id, 0);
        step_clk();
        rst = 0; idle();
        mid();
        check("rmw halted", halted, 0);
        check("rmw mem_timeout", mem_timeout, 0);
        check("rmw en_if_id", en_if_id, 1);
        step_clk();

        // Halt / single step / resume.
        halt_req = 1;
        mid(); check("hs last advance", en_if_id, 1);
        step_clk();
        load_use_inputs(); br_taken_ex = 1;
        mid();
        check("hs halted", halted, 1);
        check("hs suppressed flush", flush_id_ex, 0);
        step_clk();
        br_taken_ex = 0; is_load_ex = 0; step_req = 1;
        mid(); check("hs req cycle en", en_if_id, 0);
        step_clk(); step_req = 0;
        mid();
        check("hs step en", en_mem_wb, 1);
        check("hs step halted", halted, 0);
        step_clk();
        mid(); check("hs re-halted", halted, 1);
        step_clk();
        halt_req = 0;
        mid(); check("hs release cycle", halted, 1);
        step_clk();
        mid();
        check("hs run halted", halted, 0);
        check("hs run en", en_if_id, 1);
        step_clk();

        // Randomized phase, checked by the model.
        for (int n = 0; n < 4000; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            rf_ra0_id   = 5'($urandom_range(0, 3));
            rf_ra1_id   = 5'($urandom_range(0, 3));
            rf_re0_id   = 1'($urandom_range(0, 1));
            rf_re1_id   = 1'($urandom_range(0, 1));
            rf_ra0_ex   = 5'($urandom_range(0, 3));
            rf_ra1_ex   = 5'($urandom_range(0, 3));
            rf_wa_ex    = 5'($urandom_range(0, 3));
            rf_wa_mem   = 5'($urandom_range(0, 3));
            rf_wa_wb    = 5'($urandom_range(0, 3));
            rf_we_ex    = 1'($urandom_range(0, 1));
            rf_we_mem   = 1'($urandom_range(0, 1));
            rf_we_wb    = 1'($urandom_range(0, 1));
            is_load_ex  = 1'($urandom_range(0, 1));
            br_taken_ex = ($urandom_range(0, 4) == 0);
            dmem_req_mem = ($urandom_range(0, 2) == 0);
            dmem_ready  = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
            step_req    = ($urandom_range(0, 9) == 0);
            step_clk();
        end

        rst = 0; idle();
        step_clk();
        mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
